// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Lets two requesters share one external combinational ALU. Each request
//   moves through three stages: accept (IDLE), execute (EXEC) and respond
//   (RESP). Accepted operands and opcode are held in registers that drive
//   the ALU. The ALU result and flags are registered into a response slot,
//   and that slot holds its value until the consumer takes it.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (ready is combinational)
//   req{0,1}_a/_b/_op         request operands and ALUControl code
//   alu_a, alu_b, alu_ctrl    to the external ALU (from the op registers)
//   alu_result, alu_flags     from the external ALU, flags = {Z,N,V,C}
//   rsp_valid/_ready          response handshake
//   rsp_id/_result/_flags     registered response payload
//   op_count                  completed responses, wraps at 16 bits
module alu_req_arbiter #(
    parameter int n = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [n-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [n-1:0] a;
        logic [n-1:0] b;
        logic [3:0]   op;
        logic         id;
    } op_t;

    typedef struct packed {
        logic         id;
        logic [n-1:0] result;
        logic [3:0]   flags;
    } rsp_t;

    state_t state_q, state_d;
    logic   last_grant_q;
    op_t    op_q;
    rsp_t   rsp_q;
    logic [15:0] cnt_q;

    logic gnt;
    logic accept;
    op_t  gnt_op;

    // Round-robin arbitration: on a tie, the requester that was not granted
    // last time wins. With only one requester valid, that requester wins.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last_grant_q;
        else                          gnt = ~req0_valid;
    end

    always_comb begin
        gnt_op = gnt ? '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1}
                     : '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            rsp_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= gnt_op;
                last_grant_q <= gnt;
            end
            // The ALU is combinational, so its output is valid by the end of EXEC.
            if (state_q == EXEC)
                rsp_q <= '{id: op_q.id, result: alu_result, flags: alu_flags};
            if (state_q == RESP && rsp_ready)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign alu_a      = op_q.a;
    assign alu_b      = op_q.b;
    assign alu_ctrl   = op_q.op;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_q.id;
    assign rsp_result = rsp_q.result;
    assign rsp_flags  = rsp_q.flags;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
    localparam int N = 8;

    logic         clk, rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_ctrl, alu_flags;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [15:0]  op_count;

    typedef struct packed {
        logic         id;
        logic [N-1:0] res;
        logic [3:0]   fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_req_arbiter #(.n(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .op_count(op_count)
    );

    // ALU model: result = a + b; flags {Z,N,V,C} derived from the sum.
    logic [N:0] sum;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[N-1:0];
        alu_flags  = {sum[N-1:0] == '0, sum[N-1],
                      (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]), sum[N]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Monitor: compare each consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got id=%0d res=%h fl=%b", rsp_id, rsp_result, rsp_flags);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rsp_id, rsp_result, rsp_flags} !== e) begin
                    errors++;
                    $display("FAIL rsp_payload got id=%0d res=%h fl=%b exp id=%0d res=%h fl=%b",
                             rsp_id, rsp_result, rsp_flags, e.id, e.res, e.fl);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain got %0d pending exp 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
        chk("rst_rsp", {rsp_id, rsp_result, rsp_flags}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single request from requester 0
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'h3;
        exp_q.push_back('{1'b0, 8'h08, 4'b0000});
        @(negedge clk);
        chk("single_rdy", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        chk("single_alu", {alu_a, alu_b, alu_ctrl}, {8'h05, 8'h03, 4'h3});
        chk("single_exec_novalid", rsp_valid, 0);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        @(negedge clk);
        chk("single_count", op_count, 1);
        chk("single_rsp_drop", rsp_valid, 0);

        // Contention: both valid, grants must alternate 0,1,0,1 every 3 cycles
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h1;
        req1_valid = 1; req1_a = 8'h7F; req1_b = 8'h01; req1_op = 4'h2;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{1'b0, 8'h30, 4'b0000});
            exp_q.push_back('{1'b1, 8'h80, 4'b0110});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) chk("cont_grant", {req1_ready, req0_ready}, ((k / 3) % 2) ? 2'b10 : 2'b01);
            else            chk("cont_nogrant", {req1_ready, req0_ready}, 2'b00);
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        wait_drain("cont");
        @(negedge clk);
        chk("cont_count", op_count, 4);

        // Back-pressure plus flag capture (0xFF + 0x01)
        @(posedge clk); #1
        rsp_ready = 0;
        req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h01; req1_op = 4'hA;
        exp_q.push_back('{1'b1, 8'h00, 4'b1001});
        @(negedge clk);
        chk("bp_rdy", {req1_ready, req0_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01;
        @(negedge clk);
        chk("bp_exec_rdy", {req1_ready, req0_ready}, 2'b00);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold", {rsp_id, rsp_result, rsp_flags}, {1'b1, 8'h00, 4'b1001});
            chk("bp_rdy_low", {req1_ready, req0_ready}, 2'b00);
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_count", op_count, 5);
        chk("bp_drop", rsp_valid, 0);
        @(negedge clk);
        chk("bp_count_stable", op_count, 5);

        // Reset during EXEC discards the in-flight op
        @(posedge clk); #1 req0_valid = 1; req0_a = 8'h02; req0_b = 8'h02; req0_op = 4'h0;
        @(posedge clk); #1 req0_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_novalid", rsp_valid, 0);
            chk("rstmid_count", op_count, 0);
        end
        @(posedge clk); #1
        req0_valid = 1; req0_a = 8'h40; req0_b = 8'h40; req0_op = 4'h5;
        req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04; req1_op = 4'h6;
        exp_q.push_back('{1'b0, 8'h80, 4'b0110});
        @(negedge clk);
        chk("rstmid_tie", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        wait_drain("rstmid");
        @(negedge clk);
        chk("rstmid_count_after", op_count, 1);

        // Counter wrap: preload near the top, then complete two ops
        @(posedge clk); #1 force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        @(negedge clk);
        chk("wrap_preload", op_count, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 4'h2;
            exp_q.push_back('{1'b0, 8'h02, 4'b0000});
            @(posedge clk); #1 req0_valid = 0;
            wait_drain("wrap");
            @(negedge clk);
            chk("wrap_count", op_count, (i == 0) ? 16'hFFFF : 16'h0000);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
